// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw asynchronous level, producing a clean q plus rise/fall pulses.
// Optional push-on/push-off output tog is enabled by defining DEBOUNCE_TOGGLE_EN.
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic tog
`endif
);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  // The counter holds how many consecutive mismatching edges have been seen,
  // so the edge that would bring it to STABLE_CYCLES is the one that flips q.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               DIRECT   = (STABLE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   d_s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
    end
  end

  assign d_s  = sync_ff[SYNC_STAGES-1];
  assign qbar = ~q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
`ifdef DEBOUNCE_TOGGLE_EN
      tog   <= 1'b0;
`endif
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (d_s) begin
            if (DIRECT) begin
              state <= IDLE_HIGH;
              q     <= 1'b1;
              rise  <= 1'b1;
`ifdef DEBOUNCE_TOGGLE_EN
              tog   <= ~tog;
`endif
            end else begin
              state <= CHECK_HIGH;
              cnt   <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end
        CHECK_HIGH: begin
          if (!d_s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt >= CNT_LAST) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
            q     <= 1'b1;
            rise  <= 1'b1;
`ifdef DEBOUNCE_TOGGLE_EN
            tog   <= ~tog;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!d_s) begin
            if (DIRECT) begin
              state <= IDLE_LOW;
              q     <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= CHECK_LOW;
              cnt   <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end
        CHECK_LOW: begin
          if (d_s) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt >= CNT_LAST) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
            q     <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
          busy  <= 1'b0;
          q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed and randomized bench for debounce_sync against a window-based reference model.
// Define DEBOUNCE_TOGGLE_EN for both files to cover the tog output.
module tb_debounce_sync;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk;
  logic rst;
  logic d;
  logic q, qbar, rise, fall, busy;
`ifdef DEBOUNCE_TOGGLE_EN
  logic tog;
`endif

  debounce_sync #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q),
    .qbar(qbar),
    .rise(rise),
    .fall(fall),
    .busy(busy)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .tog (tog)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: the value seen by the debouncer at each edge is d delayed
  // through SYNC samples; q flips once the last STABLE seen values (all after
  // the previous flip) disagree with q.
  logic sq[$];
  logic hist[$];
  int   last_flip;
  logic mq, mrise, mfall, mbusy, mtog;

  int edge_n = 0;
  int rise_cnt = 0, fall_cnt = 0;
  int last_rise_edge = -1;
  int busy_start = -1, busy_end = -1;
  logic busy_prev = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    sq.delete();
    for (int i = 0; i < SYNC; i++) sq.push_front(1'b0);
    hist.delete();
    last_flip = -1;
    mq = 1'b0; mrise = 1'b0; mfall = 1'b0; mbusy = 1'b0; mtog = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_q"}, q, mq);
    chk({tag, "_qbar"}, qbar, ~mq);
    chk({tag, "_rise"}, rise, mrise);
    chk({tag, "_fall"}, fall, mfall);
    chk({tag, "_busy"}, busy, mbusy);
`ifdef DEBOUNCE_TOGGLE_EN
    chk({tag, "_tog"}, tog, mtog);
`endif
  endtask

  // driver: one clock edge, model update, then check #1 after the edge
  task automatic tick(input string tag);
    logic seen;
    logic flip;
    int   k;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      mreset();
    end else begin
      seen = sq[$];
      sq.pop_back();
      sq.push_front(d);
      hist.push_back(seen);
      k = hist.size() - 1;
      flip = ((k - last_flip) >= STABLE);
      if (flip) begin
        for (int i = 0; i < STABLE; i++)
          if (hist[k-i] == mq) flip = 1'b0;
      end
      mrise = 1'b0;
      mfall = 1'b0;
      if (flip) begin
        mq = ~mq;
        mrise = mq;
        mfall = ~mq;
        if (mq) mtog = ~mtog;
        last_flip = k;
      end
      mbusy = !flip && (seen != mq);
    end
    #1;
    check_outputs(tag);
    if (rise) begin
      rise_cnt++;
      last_rise_edge = edge_n;
    end
    if (fall) fall_cnt++;
    if (busy && !busy_prev) busy_start = edge_n;
    if (!busy && busy_prev) busy_end = edge_n;
    busy_prev = busy;
  endtask

  task automatic hold(input logic v, input int n, input string tag);
    d = v;
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int e0;
    int r0, f0;
    int dwell;
    logic bseq [5];

    // reset with d high throughout
    rst = 1'b1;
    d   = 1'b1;
    mreset();
    #2;
    chk("rst_q", q, 1'b0);
    chk("rst_qbar", qbar, 1'b1);
    chk("rst_rise", rise, 1'b0);
    chk("rst_fall", fall, 1'b0);
    chk("rst_busy", busy, 1'b0);
    #8;
    rst = 1'b0;
    e0 = edge_n + 1;
    r0 = rise_cnt;
    for (int i = 0; i < 10; i++) tick("post_rst");
    chk_int("post_rst_rise_edge", last_rise_edge - e0, 5);
    chk_int("post_rst_rise_cnt", rise_cnt - r0, 1);

    // clean press
    hold(1'b0, 10, "release1");
    e0 = edge_n + 1;
    r0 = rise_cnt;
    hold(1'b1, 10, "press");
    chk_int("press_rise_edge", last_rise_edge - e0, 5);
    chk_int("press_rise_cnt", rise_cnt - r0, 1);
    chk_int("press_busy_start", busy_start - e0, 2);
    chk_int("press_busy_end", busy_end - e0, 5);

    // glitch shorter than STABLE
    hold(1'b0, 10, "release2");
    r0 = rise_cnt;
    f0 = fall_cnt;
    e0 = edge_n + 1;
    hold(1'b1, 2, "glitch_hi");
    hold(1'b0, 10, "glitch_lo");
    chk_int("glitch_rise_cnt", rise_cnt - r0, 0);
    chk_int("glitch_fall_cnt", fall_cnt - f0, 0);
    chk_int("glitch_busy_start", busy_start - e0, 2);
    chk_int("glitch_busy_end", busy_end - e0, 4);
    chk("glitch_q", q, 1'b0);

    // bounce then hold high
    bseq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int i = 0; i < 5; i++) begin
      d = bseq[i];
      if (i == 4) e0 = edge_n + 1;
      tick("bounce");
    end
    hold(1'b1, 12, "bounce_hold");
    chk_int("bounce_rise_edge", last_rise_edge - e0, 5);
    chk_int("bounce_rise_cnt", rise_cnt - r0, 1);
    chk_int("bounce_fall_cnt", fall_cnt - f0, 0);

    // release, then async reset in the middle of the check
    f0 = fall_cnt;
    hold(1'b0, 3, "rel_chk");
    chk("rel_chk_busy_before", busy, 1'b1);
    #3;
    rst = 1'b1;
    mreset();
    #1;
    chk("arst_q", q, 1'b0);
    chk("arst_qbar", qbar, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_fall", fall, 1'b0);
    tick("arst_hold");
    tick("arst_hold");
    #2;
    rst = 1'b0;
    hold(1'b0, 10, "arst_after");
    chk_int("arst_fall_cnt", fall_cnt - f0, 0);
    chk("arst_after_q", q, 1'b0);

    // randomized dwell times, with one short asynchronous reset in the middle
    dwell = 0;
    for (int n = 0; n < 600; n++) begin
      if (dwell == 0) begin
        d = 1'($urandom_range(0, 1));
        dwell = $urandom_range(1, 8);
      end
      dwell--;
      if (n == 300) begin
        #2;
        rst = 1'b1;
        mreset();
        #2;
        rst = 1'b0;
      end
      tick("rand");
    end

`ifdef DEBOUNCE_TOGGLE_EN
    // push-on/push-off: tog follows rise only
    hold(1'b0, 12, "tog_pre");
    #2;
    rst = 1'b1;
    mreset();
    #2;
    rst = 1'b0;
    chk("tog_reset", tog, 1'b0);
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 12, "tog_press");
      chk("tog_after_press", tog, (i % 2) == 0);
      hold(1'b0, 12, "tog_release");
      chk("tog_after_release", tog, (i % 2) == 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
